// File: rtl/au_gray2bin_seq_pkg.sv
// Shared types and elaboration helpers for the multi-cycle Gray-to-binary sequencer.
package au_gray2bin_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int nstep(input int width, input int chunk);
      return (width + chunk - 1) / chunk;
   endfunction

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < value) begin
            r = r + 1;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/au_gray2bin_seq_if.sv
// Input and output valid/ready channels of the Gray-to-binary sequencer.
interface au_gray2bin_seq_if #(
   parameter int WIDTH = 32
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] g;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] b;

   modport master (
      output in_valid, g, out_ready,
      input  in_ready, out_valid, b
   );

   modport slave (
      input  in_valid, g, out_ready,
      output in_ready, out_valid, b
   );
endinterface

// File: rtl/au_gray2bin_slice.sv
// Combinational CHUNK-bit Gray-to-binary slice seeded with the carry from the chunk above.
// ARCH selects the prefix-XOR structure: 0 ripple, 1 log-depth tree, 2 sparse (pairwise) tree.
module au_gray2bin_slice
   import au_gray2bin_seq_pkg::*;
#(
   parameter int CHUNK = 8,
   parameter int ARCH  = 0
) (
   input  logic [CHUNK-1:0] g,
   input  logic             carry_in,
   output logic [CHUNK-1:0] b,
   output logic             carry_out
);
   localparam int LV = clog2(CHUNK);

   // x_s and y_s are MSB-first: position r holds chunk bit CHUNK-1-r
   logic [CHUNK-1:0] x_s;
   logic [CHUNK-1:0] y_s;

   // Reorder MSB-first and fold the incoming carry into the leading bit
   always_comb begin
      x_s = {CHUNK{1'b0}};
      for (int r = 0; r < CHUNK; r++) begin
         x_s[r] = g[CHUNK-1-r];
      end
      x_s[0] = g[CHUNK-1] ^ carry_in;
   end

   generate
      if (ARCH == 1) begin : g_tree
         // Log-depth prefix XOR: each level folds in the partial sum 2^l positions earlier
         always_comb begin
            y_s = x_s;
            for (int l = 0; l < LV; l++) begin
               y_s = y_s ^ (y_s << (1 << l));
            end
         end
      end else if (ARCH == 2) begin : g_sparse
         logic pair_acc_s;
         // Prefix carried only across bit pairs; the even positions are filled in locally
         always_comb begin
            y_s        = {CHUNK{1'b0}};
            pair_acc_s = 1'b0;
            for (int k = 0; k < CHUNK / 2; k++) begin
               y_s[2*k]   = pair_acc_s ^ x_s[2*k];
               pair_acc_s = pair_acc_s ^ x_s[2*k] ^ x_s[2*k+1];
               y_s[2*k+1] = pair_acc_s;
            end
            if ((CHUNK % 2) == 1) begin
               y_s[CHUNK-1] = pair_acc_s ^ x_s[CHUNK-1];
            end else begin
               y_s[CHUNK-1] = y_s[CHUNK-1];
            end
         end
      end else begin : g_ripple
         // Linear prefix XOR chain
         always_comb begin
            y_s = x_s;
            for (int r = 1; r < CHUNK; r++) begin
               y_s[r] = y_s[r-1] ^ x_s[r];
            end
         end
      end
   endgenerate

   // Restore LSB-first bit order for the output chunk
   always_comb begin
      b = {CHUNK{1'b0}};
      for (int r = 0; r < CHUNK; r++) begin
         b[CHUNK-1-r] = y_s[r];
      end
   end

   assign carry_out = b[0];

endmodule

// File: rtl/au_gray2bin_seq.sv
// Multi-cycle Gray-to-binary converter: one WIDTH-bit word, MSB chunk first, CHUNK bits per clock.
// Optional macro AU_GRAY2BIN_SEQ_ABORT_EN adds an abort input that cancels a word in BUSY or DONE.
module au_gray2bin_seq
   import au_gray2bin_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8,
   parameter int ARCH  = 0
) (
   input  logic clk,
   input  logic rst,
`ifdef AU_GRAY2BIN_SEQ_ABORT_EN
   input  logic abort,
`endif
   au_gray2bin_seq_if.slave bus
);
   localparam int NSTEP  = nstep(WIDTH, CHUNK);
   localparam int PW     = NSTEP * CHUNK;
   localparam int STEP_W = (NSTEP > 1) ? clog2(NSTEP) : 1;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEP - 1);

   generate
      if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || ARCH < 0 || ARCH > 2) begin : g_bad_param
         $fatal(1, "au_gray2bin_seq: illegal parameters WIDTH=%0d CHUNK=%0d ARCH=%0d", WIDTH, CHUNK, ARCH);
      end
   endgenerate

   state_t            state_r;
   logic [STEP_W-1:0] step_r;
   logic              carry_r;
   logic [PW-1:0]     gpad_r;
   logic [PW-1:0]     result_r;
   logic [PW-1:0]     result_nxt_s;
   logic [CHUNK-1:0]  chunk_g_s;
   logic [CHUNK-1:0]  chunk_b_s;
   logic              carry_out_s;

   // Step k works on chunk NSTEP-1-k: pick its Gray bits and merge its binary bits into the result
   always_comb begin
      chunk_g_s    = {CHUNK{1'b0}};
      result_nxt_s = result_r;
      for (int j = 0; j < NSTEP; j++) begin
         if (step_r == STEP_W'(NSTEP - 1 - j)) begin
            chunk_g_s                        = gpad_r[j*CHUNK +: CHUNK];
            result_nxt_s[j*CHUNK +: CHUNK]   = chunk_b_s;
         end else begin
            chunk_g_s    = chunk_g_s;
            result_nxt_s = result_nxt_s;
         end
      end
   end

   au_gray2bin_slice #(
      .CHUNK (CHUNK),
      .ARCH  (ARCH)
   ) u_slice (
      .g         (chunk_g_s),
      .carry_in  (carry_r),
      .b         (chunk_b_s),
      .carry_out (carry_out_s)
   );

   // Sequencer FSM with result, carry and step registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         step_r   <= {STEP_W{1'b0}};
         carry_r  <= 1'b0;
         gpad_r   <= {PW{1'b0}};
         result_r <= {PW{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.in_valid) begin
                  gpad_r   <= PW'(bus.g);
                  result_r <= {PW{1'b0}};
                  step_r   <= {STEP_W{1'b0}};
                  carry_r  <= 1'b0;
                  state_r  <= BUSY;
               end else begin
                  state_r  <= IDLE;
               end
            end
            BUSY: begin
`ifdef AU_GRAY2BIN_SEQ_ABORT_EN
               if (abort) begin
                  result_r <= {PW{1'b0}};
                  carry_r  <= 1'b0;
                  step_r   <= {STEP_W{1'b0}};
                  state_r  <= IDLE;
               end else
`endif
               begin
                  result_r <= result_nxt_s;
                  carry_r  <= carry_out_s;
                  if (step_r == LAST_STEP) begin
                     step_r  <= {STEP_W{1'b0}};
                     state_r <= DONE;
                  end else begin
                     step_r  <= step_r + STEP_W'(1);
                     state_r <= BUSY;
                  end
               end
            end
            DONE: begin
`ifdef AU_GRAY2BIN_SEQ_ABORT_EN
               if (abort) begin
                  result_r <= {PW{1'b0}};
                  carry_r  <= 1'b0;
                  state_r  <= IDLE;
               end else
`endif
               if (bus.out_ready) begin
                  state_r <= IDLE;
               end else begin
                  state_r <= DONE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = (state_r == IDLE) && !rst;
   assign bus.out_valid = (state_r == DONE);
   assign bus.b         = result_r[WIDTH-1:0];

   generate
      if (PW > WIDTH) begin : g_pad
         logic unused_pad_s;
         assign unused_pad_s = ^result_r[PW-1:WIDTH];
      end
   endgenerate

endmodule
